// File: rtl/led_pkg.sv
// Shared definitions for the DVI capture / LED matrix slice.
// Pixel width, default matrix geometry and capture FSM states.
package led_pkg;

    localparam int RGB_W = 24;

    localparam int MATRIX_COLS   = 64;
    localparam int MATRIX_ROWS   = 32;
    localparam int MATRIX_ADDR_W = 11;

    typedef enum logic [1:0] {
        IDLE,
        ACTIVE,
        DONE
    } cap_state_e;

endpackage

// File: rtl/dvi_sync_edge.sv
// Registers the incoming DVI controls and pixel once and derives
// the VSYNC active-edge and DE falling-edge strobes.
module dvi_sync_edge
    import led_pkg::*;
#(
    parameter bit VS_POL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             de_i,
    input  logic             vsync_i,
    input  logic [RGB_W-1:0] rgb_i,
    output logic             de_o,
    output logic [RGB_W-1:0] rgb_o,
    output logic             vs_edge_o,
    output logic             de_fall_o
);

    logic             de_q;
    logic             de_qq;
    logic             vs_act_q;
    logic             vs_act_qq;
    logic [RGB_W-1:0] rgb_q;
    logic             vs_act_d;

    assign vs_act_d = (vsync_i == VS_POL);

    // Input stage plus one history bit each for edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            de_q      <= 1'b0;
            de_qq     <= 1'b0;
            vs_act_q  <= 1'b0;
            vs_act_qq <= 1'b0;
            rgb_q     <= '0;
        end else begin
            de_q      <= de_i;
            de_qq     <= de_q;
            vs_act_q  <= vs_act_d;
            vs_act_qq <= vs_act_q;
            rgb_q     <= rgb_i;
        end
    end

    assign de_o      = de_q;
    assign rgb_o     = rgb_q;
    assign vs_edge_o = vs_act_q & ~vs_act_qq;
    assign de_fall_o = ~de_q & de_qq;

endmodule

// File: rtl/dvi_frame_capture.sv
// Crops a COLS x ROWS window out of a DVI raster, writes it to the
// back framebuffer and swaps buffers once a full window has landed.
module dvi_frame_capture
    import led_pkg::*;
#(
    parameter int H_OFFSET = 0,
    parameter int V_OFFSET = 0,
    parameter int COLS     = MATRIX_COLS,
    parameter int ROWS     = MATRIX_ROWS,
    parameter int ADDR_W   = MATRIX_ADDR_W,
    parameter bit VS_POL   = 1'b1,
    parameter int CNT_W    = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              de,
    input  logic              vsync,
    input  logic              hsync,
    input  logic [7:0]        red,
    input  logic [7:0]        green,
    input  logic [7:0]        blue,
    output logic              wr,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [RGB_W-1:0]  wr_data,
    output logic              buffer_select,
    output logic              frame_done,
    output logic [7:0]        drop_count
);

    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [CNT_W:0]    X_OFF     = (CNT_W+1)'(H_OFFSET);
    localparam logic [CNT_W:0]    Y_OFF     = (CNT_W+1)'(V_OFFSET);
    localparam logic [CNT_W:0]    W_COLS    = (CNT_W+1)'(COLS);
    localparam logic [CNT_W:0]    W_ROWS    = (CNT_W+1)'(ROWS);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(COLS*ROWS-1);

    logic             de_r;
    logic             vs_edge;
    logic             de_fall;
    logic [RGB_W-1:0] rgb_r;

    // DE alone defines lines, so HSYNC is deliberately ignored
    logic unused_hsync;
    assign unused_hsync = hsync;

    dvi_sync_edge #(
        .VS_POL(VS_POL)
    ) u_sync (
        .clk      (clk),
        .rst      (rst),
        .de_i     (de),
        .vsync_i  (vsync),
        .rgb_i    ({red, green, blue}),
        .de_o     (de_r),
        .rgb_o    (rgb_r),
        .vs_edge_o(vs_edge),
        .de_fall_o(de_fall)
    );

    logic [CNT_W-1:0] x_q, x_d;
    logic [CNT_W-1:0] y_q, y_d;

    // Raster position of the pixel currently held in the input stage
    always_comb begin
        x_d = x_q;
        if (de_fall) begin
            x_d = '0;
        end else if (de_r && (x_q != CNT_MAX)) begin
            x_d = x_q + 1'b1;
        end
        y_d = y_q;
        if (vs_edge) begin
            y_d = '0;
        end else if (de_fall && (y_q != CNT_MAX)) begin
            y_d = y_q + 1'b1;
        end
    end

    // Raster counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Offset-relative position; below-offset values wrap high and fail
    // the single unsigned range compare
    logic [CNT_W:0]    xo;
    logic [CNT_W:0]    yo;
    logic [CNT_W:0]    addr_full;
    logic [ADDR_W-1:0] waddr;
    logic              in_win;

    assign xo        = {1'b0, x_q} - X_OFF;
    assign yo        = {1'b0, y_q} - Y_OFF;
    assign in_win    = de_r && (xo < W_COLS) && (yo < W_ROWS);
    assign addr_full = (yo * W_COLS) + xo;
    assign waddr     = ADDR_W'(addr_full);

    cap_state_e        state_q;
    logic              wr_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [RGB_W-1:0]  wr_data_q;
    logic              buf_sel_q;
    logic              frame_done_q;
    logic [7:0]        drop_q;
    logic              wr_en;
    logic              last_wr;

    assign wr_en   = (state_q == ACTIVE) && enable && in_win;
    assign last_wr = wr_en && (waddr == LAST_ADDR);

    // Capture FSM: write the window, swap at the VSYNC after it completes
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            wr_q         <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            buf_sel_q    <= 1'b0;
            frame_done_q <= 1'b0;
            drop_q       <= '0;
        end else begin
            wr_q         <= wr_en;
            frame_done_q <= 1'b0;
            if (wr_en) begin
                wr_addr_q <= waddr;
                wr_data_q <= rgb_r;
            end
            unique case (state_q)
                IDLE: begin
                    if (vs_edge && enable) begin
                        state_q <= ACTIVE;
                    end
                end
                ACTIVE: begin
                    if (last_wr && vs_edge) begin
                        buf_sel_q    <= ~buf_sel_q;
                        frame_done_q <= 1'b1;
                        state_q      <= enable ? ACTIVE : IDLE;
                    end else if (last_wr) begin
                        state_q <= DONE;
                    end else if (vs_edge) begin
                        if (drop_q != 8'hFF) begin
                            drop_q <= drop_q + 8'd1;
                        end
                        state_q <= enable ? ACTIVE : IDLE;
                    end
                end
                DONE: begin
                    if (vs_edge) begin
                        buf_sel_q    <= ~buf_sel_q;
                        frame_done_q <= 1'b1;
                        state_q      <= enable ? ACTIVE : IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign wr            = wr_q;
    assign wr_addr       = wr_addr_q;
    assign wr_data       = wr_data_q;
    assign buffer_select = buf_sel_q;
    assign frame_done    = frame_done_q;
    assign drop_count    = drop_q;

endmodule

// File: doc/dvi_frame_capture.md
Name: dvi_frame_capture

Overview:
- Upstream of the LED matrix driver, in the DVI pixel-clock domain.
- Tracks raster position of the incoming DVI stream (DE/HSYNC/VSYNC/RGB) and crops a COLS x ROWS window.
- Emits one framebuffer write per cropped pixel on the matrix write port.
- Owns double-buffer selection: swaps buffer_select only after a complete window has been written.

Parameters:
H_OFFSET, 0, first captured active pixel column (counted from DE rise)
V_OFFSET, 0, first captured active line (counted from VSYNC active edge)
COLS, 64, window width; power of two
ROWS, 32, window height; power of two
ADDR_W, 11, write address width = log2(COLS*ROWS)
VS_POL, 1, VSYNC active level (1 = active-high)
CNT_W, 12, raster x/y counter width

Ports:
clk  in  1  pixel clock (PCLK); the block's only clock
rst  in  1  synchronous, active-high reset
enable  in  1  capture enable
de  in  1  DVI data enable
vsync  in  1  DVI vertical sync, polarity per VS_POL
hsync  in  1  DVI horizontal sync; accepted, unused (DE defines lines)
red  in  8  pixel red
green  in  8  pixel green
blue  in  8  pixel blue
wr  out  1  framebuffer write strobe
wr_addr  out  ADDR_W  write address, row-major: row*COLS+col
wr_data  out  24  {red,green,blue}
buffer_select  out  1  buffer the matrix displays; capture writes the other one
frame_done  out  1  one-cycle pulse on buffer swap
drop_count  out  8  partial frames discarded, saturating

Behaviour:
- Reset: wr=0, wr_addr=0, wr_data=0, buffer_select=0, frame_done=0, drop_count=0, x=y=0, state IDLE. Reset mid-frame abandons the frame without a swap.
- Input registers: de, vsync, rgb registered once. vs_edge = transition into the active level (per VS_POL). de_fall = registered de 1->0.
- x counter: increments each cycle registered de=1; clears on de_fall. y counter: increments on de_fall; clears on vs_edge. Both saturate at 2^CNT_W-1 (no wrap).
- in_win = de_r & x in [H_OFFSET, H_OFFSET+COLS) & y in [V_OFFSET, V_OFFSET+ROWS).
- Latency: pixel on the de input at cycle N -> wr=1 at cycle N+2, with wr_addr={y-V_OFFSET, x-H_OFFSET} and wr_data={r,g,b} of that pixel. wr is high for exactly one cycle per windowed pixel.
- Writes target buffer ~buffer_select (the back buffer). Buffer choice is implicit in the matrix; this block does not encode it in wr_addr.
- FSM IDLE:
  - Stays in IDLE on vs_edge when enable=0; no writes.
  - vs_edge & enable -> ACTIVE.
- FSM ACTIVE:
  - Performs writes.
  - Write of address COLS*ROWS-1 -> DONE.
  - vs_edge before that -> drop_count+1 (saturates at 255); stay ACTIVE when enable=1, go to IDLE when enable=0; no swap.
- FSM DONE:
  - No writes.
  - vs_edge -> toggle buffer_select, frame_done=1 for one cycle, then ACTIVE (enable=1) or IDLE (enable=0).
- Enable deassert mid-ACTIVE: writes stop immediately; at next vs_edge -> IDLE, counted as a drop.
- Window beyond source raster (short frame): the frame never completes; each vs_edge counts as a drop.
- vs_edge in the same cycle as the final window write: the write completes and the frame counts as complete. The swap happens at that same vs_edge, giving frame_done in the following cycle.
- Continuous DE with no de_fall: x saturates; the window is naturally exited.

Decomposition:
- Shared package led_pkg holds:
  - RGB_W=24
  - matrix geometry constants (COLS, ROWS, ADDR_W defaults)
  - the FSM state enum: IDLE, ACTIVE, DONE
- One natural sub-module: dvi_sync_edge. It handles input registration plus vs_edge/de_fall detection with the VS_POL option. Everything else stays in one module.

Test Plan:
- COLS=4, ROWS=2, offsets 0; raster 6 px x 3 lines, VSYNC pulse between frames, enable=1:
  - First frame after reset -> 8 writes, addresses 0..7, each wr_data equal to the pixel driven 2 cycles earlier.
  - Next vs_edge -> buffer_select 0->1, frame_done pulse of width 1.
- H_OFFSET=2, V_OFFSET=1, same raster -> writes only for x=2..5, lines 1..2; first wr_addr=0 carries pixel (2,1); no write for line 0.
- VSYNC asserted after only 5 writes -> drop_count=1, buffer_select unchanged, the next full frame writes from addr 0 and swaps.
- Drop enable mid-frame, re-enable -> zero writes while low; drop_count+1; capture resumes at the first vs_edge after re-enable.
- Assert rst at the 3rd write of a frame -> next cycle all outputs 0, state IDLE; no writes until the next vs_edge.
- VS_POL=0 with active-low VSYNC pulses -> identical write/swap sequence to the first scenario.
